// File: rtl/rtc_cfg_pkg.sv
// Shared definitions for the date/time configuration sequencer:
// field codes, FSM states and field wrap-around helpers.
package rtc_cfg_pkg;

    typedef logic [3:0] campo_t;

    localparam campo_t CAMPO_NINGUNO = 4'd0;
    localparam campo_t CAMPO_SEG     = 4'd1;
    localparam campo_t CAMPO_MIN     = 4'd2;
    localparam campo_t CAMPO_HORA    = 4'd3;
    localparam campo_t CAMPO_DIA     = 4'd4;
    localparam campo_t CAMPO_MES     = 4'd5;
    localparam campo_t CAMPO_ANIO    = 4'd6;
    localparam campo_t NUM_CAMPOS    = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        WRITE_REQ,
        WAIT_ACK
    } estado_t;

    // Field navigation wraps within 1..NUM_CAMPOS; "none" never appears while editing.
    function automatic campo_t campo_siguiente(input campo_t c);
        return (c >= NUM_CAMPOS) ? CAMPO_SEG : campo_t'(c + 4'd1);
    endfunction

    function automatic campo_t campo_anterior(input campo_t c);
        return (c <= CAMPO_SEG) ? NUM_CAMPOS : campo_t'(c - 4'd1);
    endfunction

endpackage

// File: rtl/generador_pulso_repeticion.sv
// Rising-edge detector with optional hold/auto-repeat timer (macro AUTO_REPEAT_EN).
// disparo is combinational; the caller registers it. enable low clears the timer.
module generador_pulso_repeticion
`ifdef AUTO_REPEAT_EN
#(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 25_000_000
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn,
    output logic disparo
);

    logic btn_prev;
    logic flanco;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_prev <= 1'b0;
        else       btn_prev <= btn;
    end

    assign flanco = btn & ~btn_prev;

`ifdef AUTO_REPEAT_EN
    localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int W       = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    logic         activo;
    logic         repitiendo;
    logic [W-1:0] cuenta;
    logic         vencido;

    // Saturating compare: the counter never needs to wrap to trigger a pulse.
    assign vencido = repitiendo ? (cuenta >= W'(REPEAT_CYC - 1))
                                : (cuenta >= W'(HOLD_CYC - 1));
    assign disparo = enable & (flanco | (activo & btn & vencido));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            activo     <= 1'b0;
            repitiendo <= 1'b0;
            cuenta     <= '0;
        end else if (!enable || !btn) begin
            activo     <= 1'b0;
            repitiendo <= 1'b0;
            cuenta     <= '0;
        end else if (flanco) begin
            activo     <= 1'b1;
            repitiendo <= 1'b0;
            cuenta     <= '0;
        end else if (activo) begin
            if (vencido) begin
                repitiendo <= 1'b1;
                cuenta     <= '0;
            end else begin
                cuenta <= cuenta + W'(1);
            end
        end
    end
`else
    assign disparo = enable & flanco;
`endif

endmodule

// File: rtl/controlador_config_fecha_hora.sv
// Date/time configuration sequencer: field select, up/down strobes and RTC write handshake.
// Auto-repeat of the up/down strobes is built only when AUTO_REPEAT_EN is defined.
module controlador_config_fecha_hora
    import rtc_cfg_pkg::*;
#(
    parameter int HOLD_CYC    = 50_000_000,
    parameter int REPEAT_CYC  = 25_000_000,
    parameter int ACK_TIMEOUT = 1024
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       wr_ack,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       modo_config,
    output logic       wr_req,
    output logic       wr_err
);

    localparam int W_ACK = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    if (HOLD_CYC < 1 || REPEAT_CYC < 1 || ACK_TIMEOUT < 1) begin : g_param_invalido
        $error("controlador_config_fecha_hora: timing parameters must be >= 1");
    end

    estado_t          estado;
    logic [W_ACK-1:0] cuenta_ack;
    logic             cfg_prev, izq_prev, der_prev;
    logic             flanco_cfg, flanco_izq, flanco_der;
    logic             habilitar_pasos;
    logic             disparo_arriba, disparo_abajo;

    assign flanco_cfg = btn_config & ~cfg_prev;
    assign flanco_izq = btn_izq    & ~izq_prev;
    assign flanco_der = btn_der    & ~der_prev;

    // Step generators run only in EDIT, are silenced by a concurrent exit, and
    // are cleared while both step buttons are held.
    assign habilitar_pasos = (estado == EDIT) & ~flanco_cfg & ~(btn_arriba & btn_abajo);

    generador_pulso_repeticion
`ifdef AUTO_REPEAT_EN
        #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
`endif
        u_arriba (
            .clk     (clk),
            .reset   (reset),
            .enable  (habilitar_pasos),
            .btn     (btn_arriba),
            .disparo (disparo_arriba)
        );

    generador_pulso_repeticion
`ifdef AUTO_REPEAT_EN
        #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
`endif
        u_abajo (
            .clk     (clk),
            .reset   (reset),
            .enable  (habilitar_pasos),
            .btn     (btn_abajo),
            .disparo (disparo_abajo)
        );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= IDLE;
            cuenta_ack  <= '0;
            cfg_prev    <= 1'b0;
            izq_prev    <= 1'b0;
            der_prev    <= 1'b0;
            contadoresH <= CAMPO_NINGUNO;
            Arriba      <= 1'b0;
            Abajo       <= 1'b0;
            modo_config <= 1'b0;
            wr_req      <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            cfg_prev <= btn_config;
            izq_prev <= btn_izq;
            der_prev <= btn_der;
            Arriba   <= 1'b0;
            Abajo    <= 1'b0;

            case (estado)
                IDLE: begin
                    if (flanco_cfg) begin
                        estado      <= EDIT;
                        contadoresH <= CAMPO_SEG;
                        modo_config <= 1'b1;
                        wr_err      <= 1'b0;
                    end
                end

                EDIT: begin
                    if (flanco_cfg) begin
                        estado      <= WRITE_REQ;
                        contadoresH <= CAMPO_NINGUNO;
                        modo_config <= 1'b0;
                        wr_req      <= 1'b1;
                        cuenta_ack  <= '0;
                    end else begin
                        if (flanco_der && !flanco_izq)
                            contadoresH <= campo_siguiente(contadoresH);
                        else if (flanco_izq && !flanco_der)
                            contadoresH <= campo_anterior(contadoresH);
                        Arriba <= disparo_arriba && (contadoresH != CAMPO_NINGUNO);
                        Abajo  <= disparo_abajo  && (contadoresH != CAMPO_NINGUNO);
                    end
                end

                // An ack in the very first request cycle is honoured here.
                WRITE_REQ: begin
                    if (wr_ack) begin
                        estado <= IDLE;
                        wr_req <= 1'b0;
                    end else begin
                        estado <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (wr_ack) begin
                        estado <= IDLE;
                        wr_req <= 1'b0;
                    end else if (cuenta_ack >= W_ACK'(ACK_TIMEOUT - 1)) begin
                        estado <= IDLE;
                        wr_req <= 1'b0;
                        wr_err <= 1'b1;
                    end else begin
                        cuenta_ack <= cuenta_ack + W_ACK'(1);
                    end
                end

                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_config_fecha_hora.sv
// Scoreboard bench for controlador_config_fecha_hora; expectations adapt to AUTO_REPEAT_EN.
module tb_controlador_config_fecha_hora;

    localparam int HOLD_CYC    = 8;
    localparam int REPEAT_CYC  = 4;
    localparam int ACK_TIMEOUT = 16;

    localparam logic [5:0] B_NADA = 6'b000000;
    localparam logic [5:0] B_CFG  = 6'b100000;
    localparam logic [5:0] B_IZQ  = 6'b010000;
    localparam logic [5:0] B_DER  = 6'b001000;
    localparam logic [5:0] B_ARR  = 6'b000100;
    localparam logic [5:0] B_ABA  = 6'b000010;
    localparam logic [5:0] B_ACK  = 6'b000001;

    localparam int S_CAMPO  = 0;
    localparam int S_ARRIBA = 1;
    localparam int S_ABAJO  = 2;
    localparam int S_MODO   = 3;
    localparam int S_REQ    = 4;
    localparam int S_ERR    = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_config = 1'b0, btn_izq = 1'b0, btn_der = 1'b0;
    logic       btn_arriba = 1'b0, btn_abajo = 1'b0, wr_ack = 1'b0;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, modo_config, wr_req, wr_err;

    typedef struct {
        int    due;
        string tag;
        int    sel;
        int    valor;
    } esperado_t;

    esperado_t cola[$];
    int        ciclo = 0;
    int        checks = 0;
    int        failures = 0;

    controlador_config_fecha_hora #(
        .HOLD_CYC    (HOLD_CYC),
        .REPEAT_CYC  (REPEAT_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_config  (btn_config),
        .btn_izq     (btn_izq),
        .btn_der     (btn_der),
        .btn_arriba  (btn_arriba),
        .btn_abajo   (btn_abajo),
        .wr_ack      (wr_ack),
        .contadoresH (contadoresH),
        .Arriba      (Arriba),
        .Abajo       (Abajo),
        .modo_config (modo_config),
        .wr_req      (wr_req),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic checkOutput(input string tag, input int observado, input int esperado);
        checks++;
        if (observado !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observado, esperado, ciclo);
        end
    endtask

    function automatic int observar(input int sel);
        case (sel)
            S_CAMPO:  return int'(contadoresH);
            S_ARRIBA: return int'(Arriba);
            S_ABAJO:  return int'(Abajo);
            S_MODO:   return int'(modo_config);
            S_REQ:    return int'(wr_req);
            default:  return int'(wr_err);
        endcase
    endfunction

    // Expected value due `off` cycles after the current drive point, kept sorted by due cycle.
    task automatic pushEsperado(input int off, input string tag, input int sel, input int valor);
        esperado_t e;
        int        pos;
        e.due   = ciclo + off;
        e.tag   = tag;
        e.sel   = sel;
        e.valor = valor;
        pos = cola.size();
        for (int i = 0; i < cola.size(); i++) begin
            if (cola[i].due > e.due) begin
                pos = i;
                break;
            end
        end
        cola.insert(pos, e);
    endtask

    task automatic pushTodoCero(input int off, input string tag);
        for (int s = S_CAMPO; s <= S_ERR; s++) pushEsperado(off, tag, s, 0);
    endtask

    // Outputs are sampled on the falling edge, midway between active edges.
    always @(negedge clk) begin
        while (cola.size() > 0 && cola[0].due <= ciclo) begin
            esperado_t e;
            e = cola.pop_front();
            checkOutput(e.tag, observar(e.sel), e.valor);
        end
    end

    task automatic applyStimulus(input logic [5:0] b);
        {btn_config, btn_izq, btn_der, btn_arriba, btn_abajo, wr_ack} = b;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulsar(input logic [5:0] b);
        applyStimulus(b);
        tick(1);
        applyStimulus(B_NADA);
        tick(1);
    endtask

    initial begin
        int der_esp[6];
        int pulso;
        der_esp = '{2, 3, 4, 5, 6, 1};

        applyStimulus(B_NADA);
        tick(3);
        reset = 1'b0;
        pushTodoCero(0, "reset_inicial");
        tick(1);

        pushEsperado(1, "entrar_campo", S_CAMPO, 1);
        pushEsperado(1, "entrar_modo", S_MODO, 1);
        pulsar(B_CFG);

        for (int i = 0; i < 6; i++) begin
            pushEsperado(1, $sformatf("der_%0d", i), S_CAMPO, der_esp[i]);
            pulsar(B_DER);
        end
        pushEsperado(1, "izq_wrap", S_CAMPO, 6);
        pulsar(B_IZQ);
        pushEsperado(1, "izq_der_juntos", S_CAMPO, 6);
        pulsar(B_IZQ | B_DER);
        pushEsperado(1, "izq_a_mes", S_CAMPO, 5);
        pulsar(B_IZQ);

        // Hold up for 20 sampled edges on field 5, then release.
        for (int k = 1; k <= 22; k++) begin
`ifdef AUTO_REPEAT_EN
            pulso = (k == 1 || k == 9 || k == 13 || k == 17) ? 1 : 0;
`else
            pulso = (k == 1) ? 1 : 0;
`endif
            pushEsperado(k, $sformatf("arriba_k%0d", k), S_ARRIBA, pulso);
        end
        pushEsperado(1, "abajo_quieto_1", S_ABAJO, 0);
        pushEsperado(9, "abajo_quieto_9", S_ABAJO, 0);
        pushEsperado(5, "campo_fijo_hold", S_CAMPO, 5);
        applyStimulus(B_ARR);
        tick(20);
        applyStimulus(B_NADA);
        tick(3);

        for (int k = 1; k <= 12; k++) begin
            pushEsperado(k, $sformatf("ambos_arr_k%0d", k), S_ARRIBA, 0);
            pushEsperado(k, $sformatf("ambos_aba_k%0d", k), S_ABAJO, 0);
        end
        applyStimulus(B_ARR | B_ABA);
        tick(12);
        applyStimulus(B_NADA);
        tick(2);

        pushEsperado(1, "salir_abajo", S_ABAJO, 0);
        pushEsperado(2, "salir_abajo_2", S_ABAJO, 0);
        pushEsperado(1, "salir_campo", S_CAMPO, 0);
        pushEsperado(1, "salir_modo", S_MODO, 0);
        pushEsperado(1, "salir_req", S_REQ, 1);
        pushEsperado(2, "wait_ack_req", S_REQ, 1);
        applyStimulus(B_CFG | B_ABA);
        tick(1);
        applyStimulus(B_NADA);
        tick(2);

        reset = 1'b1;
        pushTodoCero(1, "reset_en_wait_ack");
        tick(2);
        reset = 1'b0;
        tick(1);
        pushEsperado(1, "tras_reset_campo", S_CAMPO, 1);
        pulsar(B_CFG);

        pushEsperado(0, "req_antes", S_REQ, 0);
        pushEsperado(1, "req_c1", S_REQ, 1);
        pushEsperado(2, "req_c2", S_REQ, 1);
        pushEsperado(3, "req_c3", S_REQ, 1);
        pushEsperado(4, "req_ack_baja", S_REQ, 0);
        pushEsperado(4, "ack_sin_err", S_ERR, 0);
        pushEsperado(4, "ack_idle_campo", S_CAMPO, 0);
        pushEsperado(4, "ack_idle_modo", S_MODO, 0);
        applyStimulus(B_CFG);
        tick(1);
        applyStimulus(B_NADA);
        tick(2);
        applyStimulus(B_ACK);
        tick(1);
        applyStimulus(B_NADA);
        tick(2);

        pushEsperado(1, "idle_reentrada", S_CAMPO, 1);
        pulsar(B_CFG);

        for (int k = 1; k <= 17; k++) pushEsperado(k, $sformatf("tmo_req_k%0d", k), S_REQ, 1);
        pushEsperado(18, "tmo_req_baja", S_REQ, 0);
        pushEsperado(17, "tmo_err_aun_no", S_ERR, 0);
        pushEsperado(18, "tmo_err", S_ERR, 1);
        pushEsperado(20, "tmo_err_sticky", S_ERR, 1);
        pulsar(B_CFG);
        tick(20);

        pushEsperado(1, "reentrar_err_limpio", S_ERR, 0);
        pushEsperado(1, "reentrar_campo", S_CAMPO, 1);
        pulsar(B_CFG);

        for (int i = 0; i < 50 && cola.size() > 0; i++) tick(1);
        checkOutput("cola_pendiente", cola.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
